// File: rtl/chimp_press_encoder_if.sv
// Board-side bus of the chimp press encoder: load port, cursor/select input,
// display read port, and the press/status outputs toward control and VGA.
interface chimp_press_encoder_if #(
    parameter int CELLS = 32,
    parameter int NUMW  = 5
);
    localparam int IDXW = $clog2(CELLS);
    localparam int RW   = $clog2(CELLS + 1);

    logic            iClear;
    logic            iLoadValid;
    logic [IDXW-1:0] iLoadCell;
    logic [NUMW-1:0] iLoadNum;
    logic [IDXW-1:0] iCursorCell;
    logic            iSelect;
    logic [IDXW-1:0] iReadCell;
    logic [NUMW-1:0] oReadNum;
    logic [NUMW:0]   oPressNum;
    logic [RW-1:0]   oRemaining;
    logic            oHide;
    logic            oBusy;

    modport master (
        output iClear, iLoadValid, iLoadCell, iLoadNum, iCursorCell, iSelect, iReadCell,
        input  oReadNum, oPressNum, oRemaining, oHide, oBusy
    );

    modport slave (
        input  iClear, iLoadValid, iLoadCell, iLoadNum, iCursorCell, iSelect, iReadCell,
        output oReadNum, oPressNum, oRemaining, oHide, oBusy
    );
endinterface

// File: rtl/chimp_press_encoder.sv
// Chimp board encoder: stores cell numbers, turns a cursor + select edge into a
// one-cycle press code, clears the pressed cell and tracks remaining/hide state.
module chimp_press_encoder #(
    parameter int CELLS = 32,
    parameter int NUMW  = 5
) (
    input  logic                 clk,
    input  logic                 iResetn,
    chimp_press_encoder_if.slave bus
);
    localparam int IDXW = $clog2(CELLS);
    localparam int RW   = $clog2(CELLS + 1);

    typedef enum logic [1:0] {IDLE, LOOKUP, EMIT} state_t;

    state_t          state_q, state_d;
    logic [NUMW-1:0] cells [CELLS];
    logic [IDXW-1:0] cell_q;
    logic [NUMW-1:0] num_q;
    logic [NUMW-1:0] read_q;
    logic [NUMW:0]   press_q;
    logic [RW-1:0]   remaining_q;
    logic [RW-1:0]   rem_up, rem_dn;
    logic            hide_q;
    logic            sel_q;
    logic            sel_edge;
    logic            emit_clr, load_hits_clr, load_old_occ, load_new_occ;

    assign sel_edge = bus.iSelect & ~sel_q;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (sel_edge && !bus.iLoadValid) state_d = LOOKUP;
            LOOKUP:  state_d = EMIT;
            EMIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.iClear) state_d = IDLE;
    end

    // Count follows final cell occupancy, so a load colliding with the EMIT
    // clear of the same cell can never push the count out of 0..CELLS.
    always_comb begin
        emit_clr      = (state_q == EMIT) && (num_q != '0);
        load_hits_clr = emit_clr && bus.iLoadValid && (bus.iLoadCell == cell_q);
        load_old_occ  = (cells[bus.iLoadCell] != '0);
        load_new_occ  = (bus.iLoadNum != '0) && !load_hits_clr;
        rem_up        = '0;
        rem_dn        = '0;
        if (bus.iLoadValid) begin
            if (!load_old_occ && load_new_occ) rem_up = RW'(1);
            if (load_old_occ && !load_new_occ) rem_dn = RW'(1);
        end
        if (emit_clr && !load_hits_clr && (cells[cell_q] != '0)) rem_dn = rem_dn + RW'(1);
    end

    always_ff @(posedge clk) begin
        if (!iResetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // NOTE: the cell array is reset explicitly because reset must leave the
    // board empty; a RAM-style array without reset would power up unknown.
    always_ff @(posedge clk) begin
        if (!iResetn) begin
            for (int i = 0; i < CELLS; i++) cells[i] <= '0;
            cell_q      <= '0;
            num_q       <= '0;
            read_q      <= '0;
            press_q     <= '0;
            remaining_q <= '0;
            hide_q      <= 1'b0;
            sel_q       <= 1'b1;
        end else begin
            sel_q   <= bus.iSelect;
            read_q  <= cells[bus.iReadCell];
            press_q <= '0;
            if (bus.iClear) begin
                for (int i = 0; i < CELLS; i++) cells[i] <= '0;
                remaining_q <= '0;
                hide_q      <= 1'b0;
            end else begin
                if (bus.iLoadValid) cells[bus.iLoadCell] <= bus.iLoadNum;
                // NOTE: with non-blocking assignments the later write to the
                // same element wins, so the EMIT clear overrides a load.
                if (emit_clr) begin
                    cells[cell_q] <= '0;
                    hide_q        <= 1'b1;
                end
                remaining_q <= remaining_q + rem_up - rem_dn;
                if (state_q == IDLE && state_d == LOOKUP) cell_q <= bus.iCursorCell;
                if (state_q == LOOKUP) num_q <= cells[cell_q];
                if (state_q == EMIT) press_q <= {1'b0, num_q};
            end
        end
    end

    assign bus.oReadNum   = read_q;
    assign bus.oPressNum  = press_q;
    assign bus.oRemaining = remaining_q;
    assign bus.oHide      = hide_q;
    assign bus.oBusy      = (state_q != IDLE);
endmodule
